// File: rtl/dff_pipe_pkg.sv
// Shared definitions for the dff_pipe register pipeline.
package dff_pipe_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a data word with load, flush and async reset.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only captures real words, so bubbles passing through leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (load) begin
            valid <= load_valid;
            if (load_valid) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit bubble-collapsing register pipeline with valid/ready on both ends.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     CNT_W     = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] load_valid;
    logic [WIDTH-1:0] d         [DEPTH];
    logic [WIDTH-1:0] load_data [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage advances if anything downstream of it is empty, or the whole tail is full
    // and the consumer is taking the output word; flattened to avoid a chained vector.
    always_comb begin
        logic full_above;
        full_above = 1'b1;
        adv        = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            adv[i]     = v[i] & (~full_above | out_ready);
            full_above = full_above & v[i];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        assign load[g] = ~v[g] | adv[g];

        if (g == 0) begin : g_head
            assign load_valid[g] = in_valid;
            assign load_data[g]  = in_data;
        end else begin : g_body
            assign load_valid[g] = v[g-1];
            assign load_data[g]  = d[g-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .load       (load[g]),
            .load_valid (load_valid[g]),
            .load_data  (load_data[g]),
            .valid      (v[g]),
            .data       (d[g])
        );
    end

    assign in_ready  = ~flush & (~v[0] | adv[0]);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = v[DEPTH-1] & out_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Occupancy tracks accepted minus delivered words; flush wins over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0).
module tb_dff_pipe;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;

    int checks;
    int errors;

    dff_pipe #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data",  32'(out_data),  32'(0));
        chk("rst_count",     32'(count),     32'(0));
        chk("rst_in_ready",  32'(in_ready),  32'(1));
        tick();
        tick();
        rst_n = 1'b1;

        // 1. Streaming 0x01..0x10 with out_ready held high
        out_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            in_valid = (c <= 16);
            in_data  = 8'(c);
            tick();
            if (c >= 4 && c <= 19) begin
                chk("stream_valid", 32'(out_valid), 32'(1));
                chk("stream_data",  32'(out_data),  32'(c - 3));
            end else begin
                chk("stream_idle",  32'(out_valid), 32'(0));
            end
            if (c >= 4 && c <= 16) chk("stream_count", 32'(count), 32'(4));
        end
        chk("stream_empty", 32'(count), 32'(0));

        // 2. Fill against a stalled consumer, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            #1;
            chk("fill_in_ready", 32'(in_ready), 32'(i < 4));
            tick();
        end
        in_valid = 1'b0;
        chk("fill_count", 32'(count),     32'(4));
        chk("fill_valid", 32'(out_valid), 32'(1));
        chk("fill_data",  32'(out_data),  32'(8'hA0));
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_valid", 32'(out_valid), 32'(1));
            chk("drain_data",  32'(out_data),  32'(8'hA0 + j));
            tick();
        end
        chk("drain_empty_valid", 32'(out_valid), 32'(0));
        chk("drain_empty_count", 32'(count),     32'(0));

        // 3. Bubbles compact toward the output while stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB0; tick();
        in_valid = 1'b0;                  tick();
        in_valid = 1'b1; in_data = 8'hB1; tick();
        in_valid = 1'b0;                  tick();
        tick();
        chk("bubble_count", 32'(count),     32'(2));
        chk("bubble_valid", 32'(out_valid), 32'(1));
        chk("bubble_data",  32'(out_data),  32'(8'hB0));
        out_ready = 1'b1;
        tick();
        chk("bubble_next_valid", 32'(out_valid), 32'(1));
        chk("bubble_next_data",  32'(out_data),  32'(8'hB1));
        chk("bubble_next_count", 32'(count),     32'(1));
        tick();
        chk("bubble_empty", 32'(count), 32'(0));

        // 4. Full pipe with simultaneous in/out transfers
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            tick();
        end
        chk("full_count", 32'(count), 32'(4));
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = 8'(8'hC4 + j);
            #1;
            chk("full_in_ready", 32'(in_ready), 32'(1));
            chk("full_out_data", 32'(out_data), 32'(8'hC0 + j));
            tick();
            chk("full_count_hold", 32'(count), 32'(4));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("full_drain_valid", 32'(out_valid), 32'(1));
            chk("full_drain_data",  32'(out_data),  32'(8'hC3 + k));
            tick();
        end
        chk("full_drain_count", 32'(count), 32'(0));

        // 5. Flush with a word offered in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hD0 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("preflush_count", 32'(count),     32'(3));
        chk("preflush_data",  32'(out_data),  32'(8'hD0));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count),     32'(0));
        chk("flush_valid", 32'(out_valid), 32'(0));
        chk("flush_data",  32'(out_data),  32'(0));
        #1;
        chk("postflush_in_ready", 32'(in_ready), 32'(1));
        tick();
        chk("postflush_count", 32'(count),     32'(0));
        chk("postflush_valid", 32'(out_valid), 32'(0));

        // 6. Asynchronous reset between clock edges
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h51 + i);
            tick();
        end
        chk("prereset_count", 32'(count),    32'(4));
        chk("prereset_data",  32'(out_data), 32'(8'h52));
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_valid", 32'(out_valid), 32'(0));
        chk("areset_count", 32'(count),     32'(0));
        chk("areset_data",  32'(out_data),  32'(0));
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("postreset_valid",    32'(out_valid), 32'(0));
        chk("postreset_in_ready", 32'(in_ready),  32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
